// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//
// Multi-channel synchronizer and debouncer for the board's slide switches.
// Each raw switch level passes through a 2-FF synchronizer, then a per-channel
// stability counter. The registered output follows the synchronized input only
// after it has differed from the output for DEBOUNCE_CYCLES consecutive clocks.
// Any single cycle of agreement throws the partial count away.
//
// Parameters:
//   WIDTH           - number of independent switch channels (default 2)
//   DEBOUNCE_CYCLES - consecutive mismatch cycles needed to commit (>= 2)
//
// Ports:
//   clk     - system clock
//   rst     - asynchronous, active-high reset (clears every register)
//   sw_in   - raw, asynchronous, bouncing switch levels
//   sw_out  - debounced level, registered
//   sw_rise - one-cycle pulse, coincident with sw_out going 0->1
//   sw_fall - one-cycle pulse, coincident with sw_out going 1->0
//
// Build option:
//   SWITCH_DEBOUNCER_EDGE_EN - when defined, the sw_rise/sw_fall registers are
//   built. When undefined, both outputs are tied to 0. sw_out is unaffected.
// -----------------------------------------------------------------------------
module switch_debouncer #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] s2_r;

  // Two-stage synchronizer for all raw switch inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r <= '0;
      s2_r <= '0;
    end else begin
      s1_r <= sw_in;
      s2_r <= s1_r;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [CW-1:0] cnt_r;
    logic          out_r;
    state_t        state_s;

    // Decode this cycle's action from the synchronized input and current output.
    always_comb begin
      state_s = ST_IDLE;
      if (s2_r[i] == out_r) begin
        state_s = ST_IDLE;
      end else if (cnt_r >= CNT_MAX) begin
        // ">=" rather than "==" so an upset counter still lands in COMMIT.
        state_s = ST_COMMIT;
      end else begin
        state_s = ST_COUNT;
      end
    end

    // Stability counter and debounced output register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_r <= '0;
        out_r <= 1'b0;
      end else begin
        case (state_s)
          ST_IDLE:   cnt_r <= '0;
          ST_COUNT:  cnt_r <= cnt_r + CW'(1);
          ST_COMMIT: begin
            cnt_r <= '0;
            out_r <= s2_r[i];
          end
          default:   cnt_r <= '0;
        endcase
      end
    end

    assign sw_out[i] = out_r;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
    logic rise_r;
    logic fall_r;

    // Edge pulses register alongside the committed output, so they appear on the same edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rise_r <= 1'b0;
        fall_r <= 1'b0;
      end else begin
        case (state_s)
          ST_COMMIT: begin
            rise_r <= s2_r[i];
            fall_r <= ~s2_r[i];
          end
          default: begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
          end
        endcase
      end
    end

    assign sw_rise[i] = rise_r;
    assign sw_fall[i] = fall_r;
`else
    assign sw_rise[i] = 1'b0;
    assign sw_fall[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// Testbench for switch_debouncer (WIDTH=2, DEBOUNCE_CYCLES=8).
// The stimulus process drives sw_in/rst and, on every clock edge, pushes the
// expected outputs into a queue. The expected outputs come from a sample-history
// model: an output bit flips at the edge whose synchronized sample window, the
// last DEBOUNCE_CYCLES inputs seen two edges back, all differ from it. An extra
// all-zero entry is pushed whenever reset is raised between clock edges.
// The monitor pops one entry per falling clock edge, and one per rising edge
// of rst, then compares.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;
  localparam int W = 2;
  localparam int D = 8;

  typedef struct {
    string        tag;
    logic [W-1:0] out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw_in = '0;
  logic [W-1:0] sw_out;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;

  exp_t         q[$];
  logic [W-1:0] smp[$];
  logic [W-1:0] m_out = '0;
  string        tag = "reset_hold";
  bit           stim_done = 1'b0;
  int           vectors = 0;
  int           miscompares = 0;

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in),
    .sw_out(sw_out), .sw_rise(sw_rise), .sw_fall(sw_fall)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] sample_at(int idx);
    if (idx < 0) return '0;
    return smp[idx];
  endfunction

  // Advance the model by one rising edge and queue the expected outputs.
  task automatic edge_model();
    logic [W-1:0] r = '0;
    logic [W-1:0] f = '0;
    logic [W-1:0] s;
    exp_t e;
    int n;
    if (rst) begin
      smp.delete();
      m_out = '0;
    end else begin
      smp.push_back(sw_in);
      n = smp.size();
      for (int i = 0; i < W; i++) begin
        bit stable = 1'b1;
        for (int j = 0; j < D; j++) begin
          s = sample_at(n - 3 - j);
          if (s[i] == m_out[i]) stable = 1'b0;
        end
        if (stable) begin
          if (m_out[i] == 1'b0) r[i] = 1'b1;
          else                  f[i] = 1'b1;
          m_out[i] = ~m_out[i];
        end
      end
    end
    e.tag = tag;
    e.out = m_out;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    e.rise = r;
    e.fall = f;
`else
    e.rise = '0;
    e.fall = '0;
`endif
    q.push_back(e);
  endtask

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      edge_model();
      #1;
    end
  endtask

  // Raise reset midway between edges; outputs must clear before the next edge.
  task automatic reset_mid();
    exp_t e;
    @(negedge clk);
    #3;
    e.tag = {tag, "_async"};
    e.out = '0;
    e.rise = '0;
    e.fall = '0;
    q.push_back(e);
    rst = 1'b1;
  endtask

  // Stimulus.
  initial begin
    // Reset hold with both switches high, then release.
    sw_in = 2'b11;
    step(20);
    rst = 1'b0;
    step(12);
    sw_in = 2'b00;
    step(12);

    // Clean press and release on channel 0.
    tag = "clean";
    sw_in = 2'b01;
    step(12);
    sw_in = 2'b00;
    step(12);

    // Bounce: toggle every 3 cycles for 30 cycles, then hold high.
    tag = "bounce";
    for (int k = 0; k < 10; k++) begin
      sw_in[0] = ~sw_in[0];
      step(3);
    end
    sw_in = 2'b01;
    step(12);
    sw_in = 2'b00;
    step(12);

    // Pulse one cycle shorter than the window: rejected.
    tag = "pulse7";
    sw_in = 2'b01;
    step(D - 1);
    sw_in = 2'b00;
    step(12);

    // Pulse exactly the window length: passes, then falls.
    tag = "pulse8";
    sw_in = 2'b01;
    step(D);
    sw_in = 2'b00;
    step(20);

    // Simultaneous rise, then only channel 0 falls.
    tag = "simul";
    sw_in = 2'b11;
    step(12);
    sw_in = 2'b10;
    step(12);
    sw_in = 2'b00;
    step(12);

    // Reset in the middle of a falling count.
    tag = "rst_mid";
    sw_in = 2'b01;
    step(12);
    sw_in = 2'b00;
    step(7);
    reset_mid();
    sw_in = 2'b01;
    step(3);
    rst = 1'b0;
    step(12);
    sw_in = 2'b00;
    step(12);

    stim_done = 1'b1;
  end

  // Monitor: pop and compare one expectation per presentation point.
  initial begin
    exp_t e;
    int cyc = 0;
    forever begin
      @(negedge clk or posedge rst);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (sw_out !== e.out || sw_rise !== e.rise || sw_fall !== e.fall) begin
          miscompares++;
          $display("FAIL %s @%0t: got out=%b rise=%b fall=%b, want out=%b rise=%b fall=%b",
                   e.tag, $time, sw_out, sw_rise, sw_fall, e.out, e.rise, e.fall);
        end
      end else if (stim_done) begin
        break;
      end
      if (cyc > 5000) begin
        miscompares++;
        $display("FAIL watchdog: got %0d cycles, want at most 5000", cyc);
        break;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
